// File: rtl/back_end_pkg.sv
// Shared definitions for the back-end memory controller: FSM state
// encoding and the enum type used by the controller's state register.
package back_end_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WORK = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_WORK = WORK,
    ST_DONE = DONE
  } state_e;

endpackage

// File: rtl/back_end_port.sv
// One independent write channel: word counter, full compare and accept.
// The counter doubles as the write address, so the address presented with
// wren is the value before the increment that the accept causes.
module back_end_port
  import back_end_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_clear,
  input  logic              i_work,
  input  logic              i_send,
  input  logic [ADDR_W:0]   i_size_q,
  output logic              o_acc,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;
  logic             w_acc;

  // The counter is one bit wider than the address, so size = 2^ADDR_W
  // reaches full without wrapping; once full, no further accepts occur.
  assign w_full = (r_cnt == i_size_q);
  assign w_acc  = i_work & i_send & ~w_full;

  // Word counter: cleared when a transfer starts, advanced per accepted write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_acc  = w_acc;
  assign o_full = w_full;
  assign o_addr = r_cnt[ADDR_W-1:0];

endmodule

// File: rtl/back_end_mc.sv
// Back-end memory controller: a start/done handshake FSM that lets
// N_PORTS independent write channels each fill up to 'size' words, with a
// sticky flag recording any write attempted on an already-full channel.
module back_end_mc
  import back_end_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  input  logic                        done,
  input  logic [ADDR_W:0]             size,
  input  logic [N_PORTS-1:0]          send,
  output logic [N_PORTS-1:0]          en,
  output logic [N_PORTS-1:0]          wren,
  output logic [N_PORTS-1:0]          ack,
  output logic [N_PORTS*ADDR_W-1:0]   addr,
  output logic [N_PORTS-1:0]          full,
  output logic                        rdy,
  output logic                        complete,
  output logic                        ovf
);

  localparam int CNT_W = ADDR_W + 1;

  state_e             r_state;
  logic [CNT_W-1:0]   r_size_q;
  logic               r_rdy;
  logic               r_complete;
  logic               r_ovf;

  logic               w_work;
  logic               w_clear;
  logic               w_all_full;
  logic               w_ovf_hit;
  logic [N_PORTS-1:0] w_acc;
  logic [N_PORTS-1:0] w_full;

  assign w_work     = (r_state == ST_WORK);
  // A new transfer begins exactly on the IDLE->WORK edge.
  assign w_clear    = (r_state == ST_IDLE) & start;
  assign w_all_full = &w_full;
  assign w_ovf_hit  = w_work & (|(send & w_full));

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      back_end_port #(
        .ADDR_W (ADDR_W)
      ) u_port (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_clear  (w_clear),
        .i_work   (w_work),
        .i_send   (send[gi]),
        .i_size_q (r_size_q),
        .o_acc    (w_acc[gi]),
        .o_full   (w_full[gi]),
        .o_addr   (addr[gi*ADDR_W +: ADDR_W])
      );
    end
  endgenerate

  // Transfer FSM; rdy and complete are registered alongside the state so
  // they track WORK and DONE exactly. done takes priority over an abort.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_size_q   <= '0;
      r_rdy      <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_WORK;
            r_size_q   <= size;
            r_rdy      <= 1'b1;
            r_complete <= 1'b0;
          end else begin
            r_state    <= ST_IDLE;
            r_size_q   <= r_size_q;
            r_rdy      <= 1'b0;
            r_complete <= 1'b0;
          end
        end
        ST_WORK: begin
          r_size_q <= r_size_q;
          if (done || w_all_full) begin
            r_state    <= ST_DONE;
            r_rdy      <= 1'b0;
            r_complete <= 1'b1;
          end else if (!start) begin
            r_state    <= ST_IDLE;
            r_rdy      <= 1'b0;
            r_complete <= 1'b0;
          end else begin
            r_state    <= ST_WORK;
            r_rdy      <= 1'b1;
            r_complete <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_size_q   <= r_size_q;
          r_rdy      <= 1'b0;
          r_complete <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_size_q   <= r_size_q;
          r_rdy      <= 1'b0;
          r_complete <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: set by a send into a full channel, cleared on new start.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_hit) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign en       = w_acc;
  assign wren     = w_acc;
  assign ack      = w_acc;
  assign full     = w_full;
  assign rdy      = r_rdy;
  assign complete = r_complete;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_back_end_mc.sv
// Self-checking bench for back_end_mc (N_PORTS=2, ADDR_W=3). A reference
// model predicts each cycle's outputs; predictions are queued when the
// inputs are driven and popped when the outputs are sampled.
module tb_back_end_mc;

  localparam int NP = 2;
  localparam int AW = 3;
  localparam int CW = AW + 1;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          done;
  logic [CW-1:0] size;
  logic [NP-1:0] send;
  logic [NP-1:0] en, wren, ack, full;
  logic [NP*AW-1:0] addr;
  logic          rdy, complete, ovf;

  always #5 aclk = ~aclk;

  back_end_mc #(.N_PORTS(NP), .ADDR_W(AW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .done(done), .size(size),
    .send(send), .en(en), .wren(wren), .ack(ack), .addr(addr), .full(full),
    .rdy(rdy), .complete(complete), .ovf(ovf)
  );

  typedef struct packed {
    logic [NP-1:0]    en;
    logic [NP-1:0]    wren;
    logic [NP-1:0]    ack;
    logic [NP*AW-1:0] addr;
    logic [NP-1:0]    full;
    logic             rdy;
    logic             complete;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state: 0 idle, 1 work, 2 done
  int            m_state;
  logic [CW-1:0] m_cnt [NP];
  logic [CW-1:0] m_size;
  logic          m_ovf;

  // last sampled outputs
  logic [NP-1:0]    last_ack, last_wren;
  logic [NP*AW-1:0] last_addr;
  logic             last_complete, last_ovf, last_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < NP; i++) begin
      e.full[i] = (m_cnt[i] == m_size);
      e.ack[i]  = (m_state == 1) && send[i] && !e.full[i];
      e.en[i]   = e.ack[i];
      e.wren[i] = e.ack[i];
      e.addr[i*AW +: AW] = m_cnt[i][AW-1:0];
    end
    e.rdy      = (m_state == 1);
    e.complete = (m_state == 2);
    e.ovf      = m_ovf;
    return e;
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < NP; i++) m_cnt[i] = '0;
    m_size = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    exp_t e;
    e = model_out();
    case (m_state)
      0: if (start) begin
           m_state = 1;
           for (int i = 0; i < NP; i++) m_cnt[i] = '0;
           m_size = size;
           m_ovf  = 1'b0;
         end
      1: begin
           for (int i = 0; i < NP; i++) if (e.ack[i]) m_cnt[i] = m_cnt[i] + 4'd1;
           if ((send & e.full) != '0) m_ovf = 1'b1;
           if (done || e.full == {NP{1'b1}}) m_state = 2;
           else if (!start) m_state = 0;
         end
      default: m_state = 0;
    endcase
  endtask

  // one clock cycle: inputs are already driven (just after negedge)
  task automatic tick();
    exp_t e;
    #1;
    sb_q.push_back(model_out());
    #1;
    e = sb_q.pop_front();
    check_eq("en",       32'(en),       32'(e.en));
    check_eq("wren",     32'(wren),     32'(e.wren));
    check_eq("ack",      32'(ack),      32'(e.ack));
    check_eq("addr",     32'(addr),     32'(e.addr));
    check_eq("full",     32'(full),     32'(e.full));
    check_eq("rdy",      32'(rdy),      32'(e.rdy));
    check_eq("complete", 32'(complete), 32'(e.complete));
    check_eq("ovf",      32'(ovf),      32'(e.ovf));
    last_ack = ack; last_wren = wren; last_addr = addr;
    last_complete = complete; last_ovf = ovf; last_rdy = rdy;
    @(posedge aclk);
    if (aresetn) model_step();
    @(negedge aclk);
  endtask

  int           n_comp;
  logic [AW-1:0] seen_q[$];
  logic [3:0]   ack_hist;
  logic [3:0]   ovf_hist;

  initial begin
    aresetn = 1'b0; start = 1'b0; done = 1'b0; size = '0; send = '0;
    model_reset();
    @(negedge aclk);
    tick();
    tick();
    check_eq("rst_rdy", 32'(last_rdy), 32'd0);
    check_eq("rst_complete", 32'(last_complete), 32'd0);

    // both channels fill size=4, auto-complete, start sampled on first edge
    aresetn = 1'b1; start = 1'b1; size = 4'd4; send = 2'b11;
    n_comp = 0; seen_q.delete();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (last_wren[0]) seen_q.push_back(last_addr[AW-1:0]);
      if (last_complete) n_comp++;
      if (m_state == 2) start = 1'b0;
    end
    check_eq("a_nwrites", 32'(seen_q.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check_eq("a_addr", (k < seen_q.size()) ? 32'(seen_q[k]) : 32'hDEAD, 32'(k));
    check_eq("a_ncomplete", 32'(n_comp), 32'd1);
    check_eq("a_rdy_end", 32'(last_rdy), 32'd0);
    send = 2'b00;

    // channel 0 writes twice, then done
    start = 1'b1; size = 4'd4; tick();
    send = 2'b01; tick(); tick();
    done = 1'b1; send = 2'b00; start = 1'b0; tick();
    done = 1'b0; tick();
    check_eq("b_complete", 32'(last_complete), 32'd1);
    check_eq("b_ovf", 32'(last_ovf), 32'd0);
    tick();
    check_eq("b_addr0", 32'(last_addr[AW-1:0]), 32'd2);
    check_eq("b_addr1", 32'(last_addr[2*AW-1:AW]), 32'd0);

    // size=2, send[0] held 4 cycles: overflow then abort, then cleared
    start = 1'b1; size = 4'd2; tick();
    send = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      ack_hist[k] = last_ack[0];
      ovf_hist[k] = last_ovf;
    end
    check_eq("c_ack", 32'(ack_hist), 32'b0011);
    check_eq("c_ovf", 32'(ovf_hist), 32'b1000);
    send = 2'b00; start = 1'b0; tick();
    tick();
    check_eq("c_ovf_sticky", 32'(last_ovf), 32'd1);
    check_eq("c_no_complete", 32'(last_complete), 32'd0);
    start = 1'b1; tick();
    tick();
    check_eq("c_ovf_clr", 32'(last_ovf), 32'd0);
    start = 1'b0; tick(); tick();

    // abort after 3 writes
    start = 1'b1; size = 4'd6; tick();
    send = 2'b01; tick(); tick(); tick();
    send = 2'b00; start = 1'b0; tick();
    tick();
    check_eq("d_rdy", 32'(last_rdy), 32'd0);
    check_eq("d_complete", 32'(last_complete), 32'd0);
    check_eq("d_addr0", 32'(last_addr[AW-1:0]), 32'd3);

    // done together with sends on both channels: accepted, then DONE
    start = 1'b1; size = 4'd3; tick();
    send = 2'b11; done = 1'b1; tick();
    check_eq("e_ack", 32'(last_ack), 32'b11);
    send = 2'b00; done = 1'b0; start = 1'b0; tick();
    check_eq("e_complete", 32'(last_complete), 32'd1);
    check_eq("e_addr", 32'(last_addr), 32'b001_001);
    tick();

    // size=2^ADDR_W on channel 1: every address once, then overflow
    start = 1'b1; size = 4'd8; tick();
    send = 2'b10; seen_q.delete();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (last_wren[1]) seen_q.push_back(last_addr[2*AW-1:AW]);
    end
    check_eq("f_nwrites", 32'(seen_q.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      check_eq("f_addr", (k < seen_q.size()) ? 32'(seen_q[k]) : 32'hDEAD, 32'(k));
    check_eq("f_ovf", 32'(last_ovf), 32'd1);
    send = 2'b00; start = 1'b0; tick(); tick();

    // asynchronous reset mid-transfer, then size=0 transfer
    start = 1'b1; size = 4'd7; tick();
    send = 2'b11; tick(); tick();
    #2 aresetn = 1'b0;
    #1;
    check_eq("g_wren_async", 32'(wren), 32'd0);
    check_eq("g_rdy_async", 32'(rdy), 32'd0);
    check_eq("g_addr_async", 32'(addr), 32'd0);
    model_reset();
    @(negedge aclk);
    tick();
    aresetn = 1'b1; send = 2'b00; size = 4'd0; start = 1'b1; tick();
    start = 1'b0; tick();
    check_eq("h_rdy", 32'(last_rdy), 32'd1);
    check_eq("h_wren", 32'(last_wren), 32'd0);
    tick();
    check_eq("h_complete", 32'(last_complete), 32'd1);
    tick();
    check_eq("h_idle", 32'(last_rdy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
